// File: rtl/dsp_opt_pkg.sv
// Shared types and constants for the DSP operand-select crossbar.
package dsp_opt_pkg;

  // Constant-code offsets relative to N_IN: N_IN+0 drives 0, N_IN+1 drives 1.
  localparam int SEL_C0_OFS = 0;
  localparam int SEL_C1_OFS = 1;

  // Config load state, a pure decode of the shifted-bit count.
  typedef enum logic [1:0] {EMPTY, LOADING, FULL, OVER} cfg_state_t;

  // Select width covering every data input plus the two constant codes.
  function automatic int sel_w(input int n_in);
    return $clog2(n_in + 2);
  endfunction

endpackage

// File: rtl/dsp_opt_cfg_chain.sv
// Shadow config chain with load-length check and atomic commit to active.
module dsp_opt_cfg_chain
  import dsp_opt_pkg::*;
#(
  parameter int L = 126
) (
  input  logic         prog_clock,
  input  logic         prog_reset_n,
  input  logic         config_enable,
  input  logic         ccff_head,
  input  logic         cfg_commit,
  output logic         ccff_tail,
  output logic         cfg_ready,
  output logic         cfg_err,
  output logic [L-1:0] active
);

  localparam int              CW       = $clog2(L + 2);
  localparam logic [CW-1:0]   CNT_FULL = CW'(L);
  localparam logic [CW-1:0]   CNT_MAX  = CW'(L + 1);

  logic [L-1:0]  sr_q, act_q;
  logic [CW-1:0] cnt_q, cnt_d;
  cfg_state_t    state_q;
  logic          rdy_q, err_q;
  logic          commit_ok, commit_bad;

  function automatic cfg_state_t decode(input logic [CW-1:0] c);
    if (c == '0)      return EMPTY;
    if (c < CNT_FULL) return LOADING;
    if (c == CNT_FULL) return FULL;
    return OVER;
  endfunction

  // A commit racing a shift is refused so the copied image is always complete.
  assign commit_ok  = cfg_commit & ~config_enable & (state_q == FULL);
  assign commit_bad = cfg_commit & ~commit_ok;

  // Next count: cleared by an accepted commit, otherwise counts shifts up to L+1.
  always_comb begin
    cnt_d = cnt_q;
    if (commit_ok)
      cnt_d = '0;
    else if (config_enable && (cnt_q != CNT_MAX))
      cnt_d = cnt_q + 1'b1;
  end

  // Load FSM with registered ready/error flags.
  always_ff @(posedge prog_clock or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      cnt_q   <= '0;
      state_q <= EMPTY;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= decode(cnt_d);
      rdy_q   <= (decode(cnt_d) == FULL);
      if (commit_ok)       err_q <= 1'b0;
      else if (commit_bad) err_q <= 1'b1;
    end
  end

  // Shadow chain: new bits enter at index 0, oldest bit leaves at L-1.
  always_ff @(posedge prog_clock or negedge prog_reset_n) begin
    if (!prog_reset_n)      sr_q <= '0;
    else if (config_enable) sr_q <= {sr_q[L-2:0], ccff_head};
  end

  // Active image only ever changes as a whole, on an accepted commit.
  always_ff @(posedge prog_clock or negedge prog_reset_n) begin
    if (!prog_reset_n)  act_q <= '0;
    else if (commit_ok) act_q <= sr_q;
  end

  assign ccff_tail = sr_q[L-1];
  assign cfg_ready = rdy_q;
  assign cfg_err   = err_q;
  assign active    = act_q;

endmodule

// File: rtl/dsp_opt_xbar.sv
// Operand-select crossbar: per-output input/constant mux with optional flop.
module dsp_opt_xbar
  import dsp_opt_pkg::*;
#(
  parameter int N_IN  = 21,
  parameter int N_OUT = 21,
  parameter int SEL_W = sel_w(N_IN),
  parameter int FLD_W = SEL_W + 1,
  parameter int L     = N_OUT * FLD_W
) (
  input  logic             prog_clock,
  input  logic             prog_reset_n,
  input  logic             config_enable,
  input  logic             ccff_head,
  output logic             ccff_tail,
  input  logic             cfg_commit,
  output logic             cfg_ready,
  output logic             cfg_err,
  input  logic [N_IN-1:0]  opt_I,
  output logic [N_OUT-1:0] opt_O
);

  logic [L-1:0] active;

  dsp_opt_cfg_chain #(.L(L)) u_cfg (
    .prog_clock    (prog_clock),
    .prog_reset_n  (prog_reset_n),
    .config_enable (config_enable),
    .ccff_head     (ccff_head),
    .cfg_commit    (cfg_commit),
    .ccff_tail     (ccff_tail),
    .cfg_ready     (cfg_ready),
    .cfg_err       (cfg_err),
    .active        (active)
  );

  for (genvar k = 0; k < N_OUT; k++) begin : g_out
    logic [SEL_W-1:0] sel;
    logic             reg_en, mux, out_q;

    assign sel    = active[k*FLD_W +: SEL_W];
    assign reg_en = active[k*FLD_W + SEL_W];

    // Select an input, a constant, or 0 for codes beyond the constant range.
    always_comb begin
      mux = 1'b0;
      if (sel < SEL_W'(N_IN))
        mux = opt_I[sel];
      else if (sel == SEL_W'(N_IN + SEL_C0_OFS))
        mux = 1'b0;
      else if (sel == SEL_W'(N_IN + SEL_C1_OFS))
        mux = 1'b1;
    end

    // Output flop runs every cycle so registered mode never sees stale data.
    always_ff @(posedge prog_clock or negedge prog_reset_n) begin
      if (!prog_reset_n) out_q <= 1'b0;
      else               out_q <= mux;
    end

    assign opt_O[k] = reg_en ? out_q : mux;
  end

endmodule

// File: tb/tb_dsp_opt_xbar.sv
// Randomized bench for dsp_opt_xbar against a bit-history reference model.
module tb_dsp_opt_xbar;

  localparam int NI = 21;
  localparam int NO = 21;
  localparam int SW = 5;
  localparam int FW = 6;
  localparam int L  = 126;

  logic          prog_clock = 1'b0;
  logic          prog_reset_n, config_enable, ccff_head, cfg_commit;
  logic          ccff_tail, cfg_ready, cfg_err;
  logic [NI-1:0] opt_I;
  logic [NO-1:0] opt_O;

  int n_chk = 0;
  int n_err = 0;

  // Reference state: shift history (index 0 = most recent bit), load count,
  // sticky error, decoded active selection and per-output flop contents.
  bit hist[$];
  int m_cnt;
  bit m_err;
  int m_sel[NO];
  bit m_reg[NO];
  bit m_flop[NO];

  // Configuration about to be loaded.
  int t_sel[NO];
  bit t_reg[NO];

  dsp_opt_xbar dut (
    .prog_clock    (prog_clock),
    .prog_reset_n  (prog_reset_n),
    .config_enable (config_enable),
    .ccff_head     (ccff_head),
    .ccff_tail     (ccff_tail),
    .cfg_commit    (cfg_commit),
    .cfg_ready     (cfg_ready),
    .cfg_err       (cfg_err),
    .opt_I         (opt_I),
    .opt_O         (opt_O)
  );

  always #5 prog_clock = ~prog_clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  function automatic logic [NI-1:0] rin();
    return NI'($urandom);
  endfunction

  function automatic bit mux_ref(input int v, input logic [NI-1:0] d);
    if (v < NI) return d[v];
    return (v == NI + 1);
  endfunction

  function automatic logic [NO-1:0] exp_out();
    logic [NO-1:0] r;
    for (int k = 0; k < NO; k++)
      r[k] = m_reg[k] ? m_flop[k] : mux_ref(m_sel[k], opt_I);
    return r;
  endfunction

  task automatic model_reset();
    hist.delete();
    repeat (L) hist.push_back(1'b0);
    m_cnt = 0;
    m_err = 1'b0;
    for (int k = 0; k < NO; k++) begin
      m_sel[k] = 0; m_reg[k] = 1'b0; m_flop[k] = 1'b0;
    end
  endtask

  task automatic check_all();
    chk("opt_O",     32'(opt_O),     32'(exp_out()));
    chk("cfg_ready", 32'(cfg_ready), 32'(m_cnt == L));
    chk("cfg_err",   32'(cfg_err),   32'(m_err));
    chk("ccff_tail", 32'(ccff_tail), 32'(hist[L-1]));
  endtask

  // One clock: drive, apply the rules at the edge, check on the falling edge.
  task automatic cyc(input bit en, input bit head, input bit cm, input logic [NI-1:0] d);
    bit acc;
    int v;
    opt_I = d; config_enable = en; ccff_head = head; cfg_commit = cm;
    @(posedge prog_clock);
    for (int k = 0; k < NO; k++) m_flop[k] = mux_ref(m_sel[k], opt_I);
    acc = cm && !en && (m_cnt == L);
    if (acc) begin
      for (int k = 0; k < NO; k++) begin
        v = 0;
        for (int j = 0; j < SW; j++) if (hist[k*FW + j]) v += (1 << j);
        m_sel[k] = v;
        m_reg[k] = hist[k*FW + SW];
      end
      m_cnt = 0;
      m_err = 1'b0;
    end else begin
      if (cm) m_err = 1'b1;
      if (en) begin
        hist.push_front(head);
        void'(hist.pop_back());
        if (m_cnt < L + 1) m_cnt++;
      end
    end
    @(negedge prog_clock);
    config_enable = 1'b0; cfg_commit = 1'b0;
    check_all();
  endtask

  task automatic do_reset();
    #1;
    prog_reset_n = 1'b0;
    config_enable = 1'b0; cfg_commit = 1'b0; ccff_head = 1'b0;
    opt_I = rin();
    model_reset();
    #2;
    chk("rst_ready", 32'(cfg_ready), 32'd0);
    chk("rst_err",   32'(cfg_err),   32'd0);
    chk("rst_tail",  32'(ccff_tail), 32'd0);
    chk("rst_opt_O", 32'(opt_O),     32'({NO{opt_I[0]}}));
    @(posedge prog_clock);
    @(negedge prog_clock);
    prog_reset_n = 1'b1;
    check_all();
  endtask

  task automatic rand_cfg();
    for (int k = 0; k < NO; k++) begin
      t_sel[k] = $urandom_range(0, 31);
      t_reg[k] = 1'($urandom_range(0, 1));
    end
  endtask

  // Shift nb bits of the image; the stream ends with output 0's field.
  task automatic load(input int nb);
    logic [L-1:0] img;
    for (int k = 0; k < NO; k++) begin
      for (int j = 0; j < SW; j++) img[k*FW + j] = 1'((t_sel[k] >> j) & 1);
      img[k*FW + SW] = t_reg[k];
    end
    for (int i = nb - 1; i >= 0; i--)
      cyc(1'b1, (i < L) ? img[i] : 1'b0, 1'b0, rin());
  endtask

  task automatic commit();
    cyc(1'b0, 1'b0, 1'b1, rin());
  endtask

  logic [NI-1:0] d;

  initial begin
    prog_reset_n = 1'b0; config_enable = 1'b0; cfg_commit = 1'b0;
    ccff_head = 1'b0; opt_I = '0;
    do_reset();

    // Full load with input, constant-0 and constant-1 selections.
    rand_cfg();
    t_sel[3] = 7;  t_reg[3] = 1'b0;
    t_sel[5] = 21; t_reg[5] = 1'b0;
    t_sel[6] = 22; t_reg[6] = 1'b0;
    load(L);
    chk("full_ready", 32'(cfg_ready), 32'd1);
    commit();
    chk("full_o3",    32'(opt_O[3]),  32'(opt_I[7]));
    chk("full_o5",    32'(opt_O[5]),  32'd0);
    chk("full_o6",    32'(opt_O[6]),  32'd1);
    chk("full_rdy0",  32'(cfg_ready), 32'd0);
    chk("full_err0",  32'(cfg_err),   32'd0);

    // Registered mode: output follows the input one edge later and holds between edges.
    rand_cfg();
    t_sel[2] = 4; t_reg[2] = 1'b1;
    load(L);
    commit();
    repeat (6) begin
      d = rin();
      cyc(1'b0, 1'b0, 1'b0, d);
      chk("reg_o2", 32'(opt_O[2]), 32'(d[4]));
      opt_I = ~d;
      #1;
      chk("reg_hold", 32'(opt_O[2]), 32'(d[4]));
    end

    // Short load is refused and active config survives.
    load(L - 1);
    commit();
    chk("lenA_err", 32'(cfg_err), 32'd1);
    d = rin();
    cyc(1'b0, 1'b0, 1'b0, d);
    chk("lenA_o2", 32'(opt_O[2]), 32'(d[4]));

    // Long load is refused.
    do_reset();
    rand_cfg();
    load(L + 1);
    chk("lenB_rdy", 32'(cfg_ready), 32'd0);
    commit();
    chk("lenB_err", 32'(cfg_err), 32'd1);

    // Commit racing a shift is refused; the shift still happens.
    do_reset();
    rand_cfg();
    load(L);
    cyc(1'b1, 1'b0, 1'b1, rin());
    chk("lenC_err", 32'(cfg_err),   32'd1);
    chk("lenC_rdy", 32'(cfg_ready), 32'd0);
    chk("lenC_out", 32'(opt_O),     32'({NO{opt_I[0]}}));

    // Out-of-range select drives 0.
    do_reset();
    rand_cfg();
    t_sel[0] = 30; t_reg[0] = 1'b0;
    load(L);
    commit();
    repeat (8) begin
      cyc(1'b0, 1'b0, 1'b0, rin());
      chk("oor_o0", 32'(opt_O[0]), 32'd0);
    end

    // Marker bit travels the chain: visible on the tail after L-1 further edges.
    do_reset();
    cyc(1'b1, 1'b1, 1'b0, rin());
    for (int k = 1; k <= L; k++) begin
      cyc(1'b1, 1'b0, 1'b0, rin());
      chk("marker", 32'(ccff_tail), 32'(k == L - 1));
    end

    // Reset mid-load discards the partial load; a fresh load commits cleanly.
    do_reset();
    rand_cfg();
    load(60);
    do_reset();
    chk("mid_rdy", 32'(cfg_ready), 32'd0);
    rand_cfg();
    load(L);
    chk("mid_full", 32'(cfg_ready), 32'd1);
    commit();
    chk("mid_err", 32'(cfg_err), 32'd0);

    // Random loads of varying length with idle traffic in between.
    repeat (10) begin
      rand_cfg();
      repeat ($urandom_range(0, 4)) cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), rin());
      load(L - 1 + $urandom_range(0, 2));
      commit();
      repeat ($urandom_range(1, 5)) cyc(1'b0, 1'b0, 1'b0, rin());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
